seconds_event_tx: RTL and testbench
===================================

// Module: seconds_event_tx
// PURPOSE
//  Transmit end of the event-link seconds protocol that NTP clock logic receives.
//  On each PPS it sends the seconds-marker event code. It then shifts out the next second's count,
//  MSB first, as 32 shift-0/shift-1 event codes. Sits between the NTP clock block (PPS strobe, seconds)
//  and the event-code arbiter/serializer.
// PARAMETERS
//  CODE_SHIFT0     8'h70  event code for a 0 bit
//  CODE_SHIFT1     8'h71  event code for a 1 bit
//  CODE_MARKER     8'h7D  seconds-marker event code
//  CODE_HEARTBEAT  8'h7A  heartbeat event code (SECONDS_TX_HEARTBEAT_EN only)
//  SHIFT_DELAY     1000   clk cycles from marker acceptance to first shift event (>=1)
//  BIT_SPACING     8      min clk cycles from one accepted event to next evValid (>=1)
// PORTS
//  clk          in   1   single clock; all logic on posedge
//  reset        in   1   synchronous, active-high
//  ppsStrobe    in   1   one-cycle PPS pulse, already debounced and validated
//  secondsValid in   1   seconds count trustworthy; sampled with ppsStrobe
//  secondsNext  in   32  count receivers present after the NEXT PPS; sampled with ppsStrobe
//  evReady      in   1   arbiter accepts evCode this cycle
//  evValid      out  1   evCode is presented
//  evCode       out  8   event code
//  overrunCount out  16  saturating count of PPS arriving mid-sequence
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  - Reset: evValid=0, evCode=0, overrunCount=0, busy=0, state=IDLE, shift reg=0, bit count=0.
//  - Handshake: transfer = evValid & evReady. evValid/evCode hold stable until transfer;
//    evValid deasserts the cycle after transfer.
//  - FSM: IDLE, MARKER, DELAY, SHIFT, GAP (+HEARTBEAT when enabled).
//  - ppsStrobe at cycle N (any state):
//      latch secondsValid; if valid, load shift reg = secondsNext and bit count = 32.
//      Cycle N+1: state=MARKER, evValid=1, evCode=CODE_MARKER.
//  - MARKER on transfer: -> DELAY with counter=SHIFT_DELAY if latched valid; else -> IDLE.
//  - DELAY: decrement each cycle; at 0 -> SHIFT.
//  - SHIFT: evValid=1; evCode=shift[31] ? CODE_SHIFT1 : CODE_SHIFT0.
//    On transfer: shift<<=1, count--, -> GAP with counter=BIT_SPACING.
//  - GAP: at 0 -> SHIFT if count!=0, else -> IDLE.
//  - Pending marker not yet accepted: remains presented (no duplicate).
//  - ppsStrobe while state is DELAY/SHIFT/GAP (sequence incomplete): overrunCount++ (saturates at 16'hFFFF).
//    Remaining bits discarded; marker sequence restarts as above. A shift code presented but not yet
//    accepted is withdrawn; the marker replaces it on N+1.
//  - ppsStrobe on the same cycle as a transfer: the transfer counts as completed; restart wins.
//  - secondsValid=0 at PPS: marker only, no shift events.
//  - ppsStrobe during reset: ignored.
//  - secondsNext wraps naturally (32'hFFFFFFFF is transmitted as-is); no arithmetic on it here.
// CONFIGURATION
//  SECONDS_TX_HEARTBEAT_EN defined: after the last shift event's GAP (or after marker when not valid),
//    enter HEARTBEAT and present CODE_HEARTBEAT once, then -> IDLE.
//    A PPS during HEARTBEAT with the heartbeat not yet accepted is counted as an overrun.
//  SECONDS_TX_HEARTBEAT_EN undefined: no HEARTBEAT state; the GAP with count==0 goes directly to IDLE.
// STRUCTURE
//  Shared package (evg_pkg): event-code constants (SHIFT0/1, MARKER, HEARTBEAT) and FSM state encoding
//  localparams. One sub-module natural: event_slot_hold (valid/code register with hold-until-ready and
//  withdraw-on-restart). The counters and FSM stay in the top level.
// TESTING
//  1. secondsValid=1, secondsNext=32'h8000_0001, evReady=1, SHIFT_DELAY=4, BIT_SPACING=2 ->
//     7D; then 71, 30x 70, 71 MSB first; each evValid spaced per parameters.
//  2. secondsValid=0 at PPS -> exactly one 7D, busy falls after transfer, no 70/71.
//  3. evReady held 0 for 50 cycles during marker -> 7D held stable, single transfer when ready rises.
//  4. Second PPS after 10 bits sent -> overrunCount=1; next event 7D; full 32 bits of new secondsNext follow.
//  5. secondsNext=32'hFFFF_FFFF -> 32x 71; reset asserted mid-SHIFT -> next cycle evValid=0,
//     overrunCount=0, IDLE.
//  6. SECONDS_TX_HEARTBEAT_EN defined -> 7A after the 32nd bit's gap; undefined -> no 7A ever.

Source files
------------

// File: rtl/evg_pkg.sv
// Shared event-link definitions: event codes, FSM state encoding and the
// helper that maps a seconds bit onto its shift event code.
package evg_pkg;

   localparam logic [7:0] CODE_SHIFT0    = 8'h70;
   localparam logic [7:0] CODE_SHIFT1    = 8'h71;
   localparam logic [7:0] CODE_MARKER    = 8'h7D;
   localparam logic [7:0] CODE_HEARTBEAT = 8'h7A;

   localparam int unsigned SECONDS_BITS = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MARKER    = 3'd1,
      ST_DELAY     = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_GAP       = 3'd4,
      ST_HEARTBEAT = 3'd5
   } state_t;

   function automatic logic [7:0] shift_code(input logic bit_value);
      return bit_value ? CODE_SHIFT1 : CODE_SHIFT0;
   endfunction

endpackage

// File: rtl/seconds_event_tx_if.sv
// Signals between the NTP clock block, the seconds transmitter and the
// event-code arbiter. master = transmitter, slave = its environment.
interface seconds_event_tx_if;

   logic        ppsStrobe;
   logic        secondsValid;
   logic [31:0] secondsNext;
   logic        evReady;
   logic        evValid;
   logic [7:0]  evCode;
   logic [15:0] overrunCount;
   logic        busy;

   modport master (
      input  ppsStrobe, secondsValid, secondsNext, evReady,
      output evValid, evCode, overrunCount, busy
   );

   modport slave (
      output ppsStrobe, secondsValid, secondsNext, evReady,
      input  evValid, evCode, overrunCount, busy
   );

endinterface

// File: rtl/event_slot_hold.sv
// Single-entry event slot: holds valid/code until the arbiter takes it.
// A new load always wins, which is how a restart withdraws a pending code.
module event_slot_hold (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_load,
   input  logic [7:0] i_code,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [7:0] o_code
);

   logic       r_valid;
   logic [7:0] r_code;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_code  <= 8'h00;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_code  <= i_code;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_code  = r_code;

endmodule

// File: rtl/seconds_event_tx.sv
// Seconds-marker transmitter: marker on PPS, then next second's count as 32
// shift events MSB first. Define SECONDS_TX_HEARTBEAT_EN for a trailing heartbeat.
module seconds_event_tx
   import evg_pkg::*;
#(
   parameter int unsigned SHIFT_DELAY = 1000,
   parameter int unsigned BIT_SPACING = 8
) (
   input logic                clk,
   input logic                reset,
   seconds_event_tx_if.master io_bus
);

   localparam int unsigned TIMER_MAX = (SHIFT_DELAY > BIT_SPACING) ? SHIFT_DELAY : BIT_SPACING;
   localparam int          TIMER_W   = $clog2(TIMER_MAX + 1);
   localparam int          BITS_W    = $clog2(SECONDS_BITS + 1);

   state_t             r_state;
   logic               r_sec_valid;
   logic [31:0]        r_shift;
   logic [BITS_W-1:0]  r_bits;
   logic [TIMER_W-1:0] r_timer;
   logic [15:0]        r_overrun;

   logic       w_valid;
   logic [7:0] w_ev_code;
   logic       w_transfer;
   logic       w_timer_done;
   logic       w_load;
   logic [7:0] w_code;
   logic       w_overrun;

   assign w_transfer   = w_valid & io_bus.evReady;
   // Timer expires as it would reach zero, so a load of N gives exactly N cycles.
   assign w_timer_done = (r_timer <= TIMER_W'(1));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_load    = 1'b0;
      w_code    = CODE_MARKER;
      w_overrun = 1'b0;
      if (io_bus.ppsStrobe) begin
         w_load = 1'b1;
         case (r_state)
            ST_DELAY, ST_SHIFT, ST_GAP: w_overrun = 1'b1;
`ifdef SECONDS_TX_HEARTBEAT_EN
            ST_HEARTBEAT:               w_overrun = !w_transfer;
`endif
            default:                    w_overrun = 1'b0;
         endcase
      end else begin
         case (r_state)
            ST_DELAY: begin
               if (w_timer_done) begin
                  w_load = 1'b1;
                  w_code = shift_code(r_shift[31]);
               end
            end
            ST_GAP: begin
               if (w_timer_done && r_bits != '0) begin
                  w_load = 1'b1;
                  w_code = shift_code(r_shift[31]);
               end
`ifdef SECONDS_TX_HEARTBEAT_EN
               else if (w_timer_done) begin
                  w_load = 1'b1;
                  w_code = CODE_HEARTBEAT;
               end
`endif
            end
`ifdef SECONDS_TX_HEARTBEAT_EN
            ST_MARKER: begin
               if (w_transfer && !r_sec_valid) begin
                  w_load = 1'b1;
                  w_code = CODE_HEARTBEAT;
               end
            end
`endif
            default: w_load = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sec_valid <= 1'b0;
         r_shift     <= '0;
         r_bits      <= '0;
         r_timer     <= '0;
         r_overrun   <= '0;
      end else if (io_bus.ppsStrobe) begin
         r_state     <= ST_MARKER;
         r_sec_valid <= io_bus.secondsValid;
         if (io_bus.secondsValid) begin
            r_shift <= io_bus.secondsNext;
            r_bits  <= BITS_W'(SECONDS_BITS);
         end
         if (w_overrun && r_overrun != 16'hFFFF)
            r_overrun <= r_overrun + 16'd1;
      end else begin
         case (r_state)
            ST_MARKER: begin
               if (w_transfer) begin
                  if (r_sec_valid) begin
                     r_state <= ST_DELAY;
                     r_timer <= TIMER_W'(SHIFT_DELAY);
                  end else begin
`ifdef SECONDS_TX_HEARTBEAT_EN
                     r_state <= ST_HEARTBEAT;
`else
                     r_state <= ST_IDLE;
`endif
                  end
               end
            end
            ST_DELAY: begin
               if (w_timer_done) r_state <= ST_SHIFT;
               else              r_timer <= r_timer - TIMER_W'(1);
            end
            ST_SHIFT: begin
               if (w_transfer) begin
                  r_shift <= {r_shift[30:0], 1'b0};
                  r_bits  <= r_bits - BITS_W'(1);
                  r_timer <= TIMER_W'(BIT_SPACING);
                  r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (!w_timer_done)      r_timer <= r_timer - TIMER_W'(1);
               else if (r_bits != '0)  r_state <= ST_SHIFT;
`ifdef SECONDS_TX_HEARTBEAT_EN
               else                    r_state <= ST_HEARTBEAT;
`else
               else                    r_state <= ST_IDLE;
`endif
            end
            ST_HEARTBEAT: begin
               if (w_transfer) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   event_slot_hold u_slot (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_code  (w_code),
      .i_ready (io_bus.evReady),
      .o_valid (w_valid),
      .o_code  (w_ev_code)
   );

   assign io_bus.evValid      = w_valid;
   assign io_bus.evCode       = w_ev_code;
   assign io_bus.overrunCount = r_overrun;
   assign io_bus.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seconds_event_tx.sv
// Directed bench for seconds_event_tx with SHIFT_DELAY=4, BIT_SPACING=2.
// With evReady held high, marker->first shift transfer is D+1 edges apart and shift->shift is S+1.
module tb_seconds_event_tx;

   localparam int unsigned D = 4;
   localparam int unsigned S = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   seconds_event_tx_if bus ();

   seconds_event_tx #(.SHIFT_DELAY(D), .BIT_SPACING(S)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   int     n_checks = 0;
   int     n_errors = 0;
   longint cyc = 0;
   longint last_edge = 0;
   logic [7:0] cap_code [32];
   longint     cap_gap  [32];
   int         cap_got;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.ppsStrobe = 1'b0;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   task automatic pulse_pps(input logic valid, input logic [31:0] nxt);
      bus.secondsValid = valid;
      bus.secondsNext  = nxt;
      bus.ppsStrobe    = 1'b1;
      step(1);
      bus.ppsStrobe    = 1'b0;
      bus.secondsValid = 1'b0;
      bus.secondsNext  = 32'h0;
   endtask

   // Steps until a transfer edge has passed; reports code and edges since the previous transfer.
   task automatic wait_transfer(input int budget, output logic [7:0] code, output longint gap, output bit ok);
      ok = 1'b0;
      code = 8'h00;
      gap = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (bus.evValid === 1'b1 && bus.evReady === 1'b1) begin
            code = bus.evCode;
            ok = 1'b1;
         end
         step(1);
      end
      if (ok) begin
         gap = cyc - last_edge;
         last_edge = cyc;
      end
   endtask

   task automatic capture(input int n);
      logic [7:0] c;
      longint g;
      bit ok;
      cap_got = 0;
      for (int i = 0; i < n; i++) begin
         wait_transfer(100, c, g, ok);
         if (!ok) break;
         cap_code[i] = c;
         cap_gap[i]  = g;
         cap_got++;
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (bus.busy === 1'b0) ok = 1'b1;
         else step(1);
      end
   endtask

   task automatic test_reset();
      step(3);
      n_checks++;
      if (bus.evValid !== 1'b0 || bus.evCode !== 8'h00 || bus.overrunCount !== 16'h0 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state: got valid=%b code=%h ovr=%h busy=%b required 0/00/0000/0",
                  bus.evValid, bus.evCode, bus.overrunCount, bus.busy);
      end
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_basic();
      logic [31:0] val = 32'h8000_0001;
      logic [7:0] c;
      longint g;
      bit ok;
      bus.evReady = 1'b1;
      pulse_pps(1'b1, val);
      n_checks++;
      if (bus.evValid !== 1'b1 || bus.evCode !== 8'h7D || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_marker_present: got valid=%b code=%h busy=%b required 1/7d/1", bus.evValid, bus.evCode, bus.busy);
      end
      wait_transfer(10, c, g, ok);
      n_checks++;
      if (!ok || c !== 8'h7D) begin
         n_errors++;
         $display("FAIL basic_marker_xfer: got ok=%0d code=%h required 1/7d", ok, c);
      end
      capture(32);
      n_checks++;
      if (cap_got != 32) begin
         n_errors++;
         $display("FAIL basic_bit_count: got %0d required 32", cap_got);
      end
      for (int i = 0; i < cap_got; i++) begin
         n_checks++;
         if (cap_code[i] !== (val[31-i] ? 8'h71 : 8'h70)) begin
            n_errors++;
            $display("FAIL basic_bit%0d_code: got %h required %h", i, cap_code[i], val[31-i] ? 8'h71 : 8'h70);
         end
         n_checks++;
         if (cap_gap[i] != ((i == 0) ? longint'(D + 1) : longint'(S + 1))) begin
            n_errors++;
            $display("FAIL basic_bit%0d_spacing: got %0d required %0d", i, cap_gap[i], (i == 0) ? D + 1 : S + 1);
         end
      end
   endtask

   task automatic test_tail();
`ifdef SECONDS_TX_HEARTBEAT_EN
      logic [7:0] c;
      longint g;
      bit ok;
      wait_transfer(20, c, g, ok);
      n_checks++;
      if (!ok || c !== 8'h7A || g != longint'(S + 1)) begin
         n_errors++;
         $display("FAIL tail_heartbeat: got ok=%0d code=%h gap=%0d required 1/7a/%0d", ok, c, g, S + 1);
      end
`else
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.evValid !== 1'b0) seen++;
         step(1);
      end
      n_checks++;
      if (seen != 0) begin
         n_errors++;
         $display("FAIL tail_no_event: got %0d valid cycles required 0", seen);
      end
`endif
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL tail_idle: got busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_invalid();
      logic [7:0] c;
      longint g;
      bit ok;
      int seen = 0;
      bus.evReady = 1'b1;
      pulse_pps(1'b0, 32'hDEAD_BEEF);
      wait_transfer(10, c, g, ok);
      n_checks++;
      if (!ok || c !== 8'h7D) begin
         n_errors++;
         $display("FAIL invalid_marker: got ok=%0d code=%h required 1/7d", ok, c);
      end
`ifdef SECONDS_TX_HEARTBEAT_EN
      wait_transfer(10, c, g, ok);
      n_checks++;
      if (!ok || c !== 8'h7A || g != 1) begin
         n_errors++;
         $display("FAIL invalid_heartbeat: got ok=%0d code=%h gap=%0d required 1/7a/1", ok, c, g);
      end
`endif
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL invalid_busy_fall: got busy=%b required 0", bus.busy);
      end
      for (int i = 0; i < 40; i++) begin
         if (bus.evValid !== 1'b0) seen++;
         step(1);
      end
      n_checks++;
      if (seen != 0) begin
         n_errors++;
         $display("FAIL invalid_no_shift: got %0d valid cycles required 0", seen);
      end
   endtask

   task automatic test_ready_hold();
      logic [7:0] c;
      longint g;
      bit ok;
      int bad = 0;
      bus.evReady = 1'b0;
      pulse_pps(1'b1, 32'h0000_00FF);
      for (int i = 0; i < 25; i++) begin
         if (bus.evValid !== 1'b1 || bus.evCode !== 8'h7D) bad++;
         step(1);
      end
      pulse_pps(1'b1, 32'h0000_00FF);
      for (int i = 0; i < 25; i++) begin
         if (bus.evValid !== 1'b1 || bus.evCode !== 8'h7D) bad++;
         step(1);
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL hold_marker_stable: got %0d unstable cycles required 0", bad);
      end
      n_checks++;
      if (bus.overrunCount !== 16'h0) begin
         n_errors++;
         $display("FAIL hold_no_overrun: got %h required 0000", bus.overrunCount);
      end
      bus.evReady = 1'b1;
      wait_transfer(5, c, g, ok);
      n_checks++;
      if (!ok || c !== 8'h7D || bus.evValid !== 1'b0) begin
         n_errors++;
         $display("FAIL hold_single_xfer: got ok=%0d code=%h valid_after=%b required 1/7d/0", ok, c, bus.evValid);
      end
      apply_reset();
   endtask

   task automatic test_overrun();
      logic [31:0] v1 = 32'hA5A5_0F0F;
      logic [31:0] v2 = 32'h1234_5678;
      logic [7:0] c;
      longint g;
      bit ok;
      bus.evReady = 1'b1;
      pulse_pps(1'b1, v1);
      wait_transfer(10, c, g, ok);
      capture(10);
      n_checks++;
      if (cap_got != 10 || cap_code[9] !== (v1[22] ? 8'h71 : 8'h70)) begin
         n_errors++;
         $display("FAIL ovr_first_bits: got %0d bits last=%h required 10/%h", cap_got, cap_code[9], v1[22] ? 8'h71 : 8'h70);
      end
      pulse_pps(1'b1, v2);
      n_checks++;
      if (bus.overrunCount !== 16'd1 || bus.evValid !== 1'b1 || bus.evCode !== 8'h7D) begin
         n_errors++;
         $display("FAIL ovr_restart: got ovr=%0d valid=%b code=%h required 1/1/7d", bus.overrunCount, bus.evValid, bus.evCode);
      end
      wait_transfer(10, c, g, ok);
      capture(32);
      n_checks++;
      if (cap_got != 32) begin
         n_errors++;
         $display("FAIL ovr_bit_count: got %0d required 32", cap_got);
      end
      for (int i = 0; i < cap_got; i++) begin
         n_checks++;
         if (cap_code[i] !== (v2[31-i] ? 8'h71 : 8'h70)) begin
            n_errors++;
            $display("FAIL ovr_bit%0d_code: got %h required %h", i, cap_code[i], v2[31-i] ? 8'h71 : 8'h70);
         end
      end
      wait_idle(50, ok);
      // Presented-but-unaccepted shift code must be replaced by the new marker.
      pulse_pps(1'b1, 32'h4000_0000);
      wait_transfer(10, c, g, ok);
      bus.evReady = 1'b0;
      for (int i = 0; i < 20 && bus.evValid !== 1'b1; i++) step(1);
      n_checks++;
      if (bus.evValid !== 1'b1 || bus.evCode !== 8'h70) begin
         n_errors++;
         $display("FAIL ovr_shift_pending: got valid=%b code=%h required 1/70", bus.evValid, bus.evCode);
      end
      pulse_pps(1'b1, 32'h0);
      n_checks++;
      if (bus.evValid !== 1'b1 || bus.evCode !== 8'h7D || bus.overrunCount !== 16'd2) begin
         n_errors++;
         $display("FAIL ovr_withdraw: got valid=%b code=%h ovr=%0d required 1/7d/2", bus.evValid, bus.evCode, bus.overrunCount);
      end
      bus.evReady = 1'b1;
      apply_reset();
   endtask

   task automatic test_all_ones_reset();
      logic [7:0] c;
      longint g;
      bit ok;
      int bad = 0;
      bus.evReady = 1'b1;
      pulse_pps(1'b1, 32'hFFFF_FFFF);
      wait_transfer(10, c, g, ok);
      capture(32);
      for (int i = 0; i < cap_got; i++) if (cap_code[i] !== 8'h71) bad++;
      n_checks++;
      if (cap_got != 32 || bad != 0) begin
         n_errors++;
         $display("FAIL ones_bits: got %0d bits with %0d not 71 required 32/0", cap_got, bad);
      end
      wait_idle(50, ok);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL ones_idle: got busy=%b required 0 within budget", bus.busy);
      end
      pulse_pps(1'b1, 32'hFFFF_FFFF);
      wait_transfer(10, c, g, ok);
      capture(3);
      pulse_pps(1'b1, 32'hFFFF_FFFF);
      n_checks++;
      if (bus.overrunCount !== 16'd1) begin
         n_errors++;
         $display("FAIL ones_overrun: got %0d required 1", bus.overrunCount);
      end
      wait_transfer(10, c, g, ok);
      bus.evReady = 1'b0;
      for (int i = 0; i < 20 && bus.evValid !== 1'b1; i++) step(1);
      n_checks++;
      if (bus.evValid !== 1'b1 || bus.evCode !== 8'h71 || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL ones_mid_shift: got valid=%b code=%h busy=%b required 1/71/1", bus.evValid, bus.evCode, bus.busy);
      end
      reset = 1'b1;
      bus.ppsStrobe = 1'b1;
      step(1);
      n_checks++;
      if (bus.evValid !== 1'b0 || bus.overrunCount !== 16'h0 || bus.busy !== 1'b0 || bus.evCode !== 8'h00) begin
         n_errors++;
         $display("FAIL ones_reset: got valid=%b ovr=%h busy=%b code=%h required 0/0000/0/00",
                  bus.evValid, bus.overrunCount, bus.busy, bus.evCode);
      end
      step(2);
      reset = 1'b0;
      bus.ppsStrobe = 1'b0;
      step(5);
      n_checks++;
      if (bus.evValid !== 1'b0 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL ones_pps_in_reset: got valid=%b busy=%b required 0/0", bus.evValid, bus.busy);
      end
      bus.evReady = 1'b1;
   endtask

   initial begin
      bus.ppsStrobe    = 1'b0;
      bus.secondsValid = 1'b0;
      bus.secondsNext  = 32'h0;
      bus.evReady      = 1'b0;
      test_reset();
      test_basic();
      test_tail();
      test_invalid();
      test_ready_hold();
      test_overrun();
      test_all_ones_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
